multicycle_ctrl_fsm: RTL

//  Main control FSM for the multicycle RISC-V core.
//  - Sequences the shared ALU, instruction register, PC and memory port through fetch/decode/execute/writeback.
//  - Drives alu_op into alu_decoder: 00 add, 01 sub, 10 funct-decoded.
//  - Supports lw, sw, R-type, I-type ALU, beq and jal.
//  - Handles a ready handshake on the unified memory port.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 62 ++++++
 rtl/ctrl_out_decode.sv | 91 +++++++++
 rtl/multicycle_ctrl_fsm.sv | 85 ++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multicycle RISC-V control path: opcodes, FSM states, mux selects.
// Also holds the packed control bundle passed from the output decoder to the FSM top.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> select/enable table; zero latency.
// Only FETCH, MEMWRITE, BEQ and DECODE look at inputs (mem_rdy, zero, opcode).
module ctrl_out_decode
  import riscv_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_rdy;
        ctrl.pc_write   = mem_rdy;
      end
      S_DECODE: begin
        // Branch target PC+imm is precomputed here into ALUOut.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (!is_supported(opcode)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.instr_done = mem_rdy;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle control FSM: lw 5, sw/R/I/jal 4, beq 3 cycles at zero wait.
// FETCH, MEMREAD and MEMWRITE stall on mem_ready when MEM_WAIT_EN=1.
module multicycle_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state;
  logic   mem_rdy;
  ctrl_t  ctrl;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= mem_rdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BEQ;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= mem_rdy ? S_MEMWB : S_MEMREAD;
        S_MEMWRITE: state <= mem_rdy ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  ctrl_out_decode u_decode (
    .state   (state),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Reset gates the enables combinationally so an in-flight write dies with rst_n.
  assign mem_req    = ctrl.mem_req    & rst_n;
  assign ir_write   = ctrl.ir_write   & rst_n;
  assign pc_write   = ctrl.pc_write   & rst_n;
  assign reg_write  = ctrl.reg_write  & rst_n;
  assign mem_write  = ctrl.mem_write  & rst_n;
  assign instr_done = ctrl.instr_done & rst_n;
  assign illegal_op = ctrl.illegal_op & rst_n;

  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_op     = ctrl.alu_op;
  assign state_o    = state;

endmodule
